// File: rtl/sd_seq_tx.sv
// sd_seq_tx - serial frame transmitter for the 1011 sequence detectors.
//
// A parallel word accepted over load/ready is sent one bit per clock on
// seq_out. The word is preceded by a fixed sync header (MSB first) and
// followed by GAP_LEN low guard cycles. After each frame the block spends
// one mandatory IDLE cycle with ready high before it can accept again.
//
// Ports:
//   clk         single clock, rising-edge
//   rst         synchronous, active-low reset
//   data_in     WIDTH-bit word, sampled only on the accept edge
//   load        transmit request, honoured only in IDLE
//   ready       high only in IDLE (combinational state decode)
//   seq_out     registered serial output
//   busy        high in HDR, DATA and GAP
//   frame_done  registered pulse, high while the last data bit is on seq_out
//   state_out   IDLE=000, HDR=001, DATA=010, GAP=011
module sd_seq_tx #(
    parameter int                 WIDTH   = 8,
    parameter int                 HDR_LEN = 4,
    parameter logic [HDR_LEN-1:0] HDR     = 4'b1011,
    parameter int                 GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             seq_out,
    output logic             busy,
    output logic             frame_done,
    output logic [2:0]       state_out
);

    localparam int TOT   = HDR_LEN + WIDTH;
    localparam int MAX_A = (HDR_LEN > WIDTH) ? HDR_LEN : WIDTH;
    localparam int MAXV  = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
    localparam int CW    = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_HDR  = 3'b001;
    localparam logic [2:0] S_DATA = 3'b010;
    localparam logic [2:0] S_GAP  = 3'b011;

    logic [2:0]     state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [TOT-1:0] shift_reg;
    logic           seq_reg;
    logic           done_reg;

    // Header and data share one shift register. The header MSB goes out
    // directly on the accept edge, so the register is loaded pre-shifted
    // and its top bit is always the next bit to emit. cnt_reg holds the
    // number of bits still to follow in the current phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            seq_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    seq_reg  <= 1'b0;
                    done_reg <= 1'b0;
                    if (load) begin
                        state_reg <= S_HDR;
                        shift_reg <= {HDR, data_in} << 1;
                        seq_reg   <= HDR[HDR_LEN-1];
                        cnt_reg   <= CW'(HDR_LEN - 1);
                    end
                end
                S_HDR: begin
                    seq_reg   <= shift_reg[TOT-1];
                    shift_reg <= shift_reg << 1;
                    if (cnt_reg == '0) begin
                        // Next bit is the data MSB.
                        state_reg <= S_DATA;
                        cnt_reg   <= CW'(WIDTH - 1);
                        done_reg  <= (WIDTH == 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == '0) begin
                        seq_reg  <= 1'b0;
                        done_reg <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state_reg <= S_GAP;
                            cnt_reg   <= CW'(GAP_LEN - 1);
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        seq_reg   <= shift_reg[TOT-1];
                        shift_reg <= shift_reg << 1;
                        cnt_reg   <= cnt_reg - 1'b1;
                        // Pulse accompanies the final data bit.
                        done_reg  <= (cnt_reg == CW'(1));
                    end
                end
                S_GAP: begin
                    seq_reg  <= 1'b0;
                    done_reg <= 1'b0;
                    if (cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    seq_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign seq_out    = seq_reg;
    assign frame_done = done_reg;
    assign state_out  = state_reg;

endmodule

// File: tb/tb_sd_seq_tx.sv
// Bench for sd_seq_tx: a default instance (8-bit word, 2 gap cycles) and a
// compact instance (4-bit word, no gap). Both are checked every cycle
// against a frame-position model derived from the frame timing rules.
module tb_sd_seq_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic       rst_a = 1'b0, load_a = 1'b0;
    logic [7:0] data_a = '0;
    logic       ready_a, seq_a, busy_a, done_a;
    logic [2:0] st_a;

    // Short instance: WIDTH=4, GAP_LEN=0
    logic       rst_b = 1'b0, load_b = 1'b0;
    logic [3:0] data_b = '0;
    logic       ready_b, seq_b, busy_b, done_b;
    logic [2:0] st_b;

    sd_seq_tx dut_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .load(load_a),
        .ready(ready_a), .seq_out(seq_a), .busy(busy_a),
        .frame_done(done_a), .state_out(st_a)
    );

    sd_seq_tx #(.WIDTH(4), .HDR_LEN(4), .HDR(4'b1011), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .load(load_b),
        .ready(ready_b), .seq_out(seq_b), .busy(busy_b),
        .frame_done(done_b), .state_out(st_b)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Model: pos=0 means idle; pos=k (k>=1) means the k-th cycle after accept.
    int          pos_a = 0, pos_b = 0;
    logic [63:0] bits_a = '0, bits_b = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_step(input string nm, input int h, input int w, input int g,
                              input logic r, input logic l, input logic [31:0] d,
                              inout int pos, inout logic [63:0] bits);
        if (!r) begin
            pos = 0;
        end else if (pos == 0) begin
            if (l) begin
                pos  = 1;
                bits = (64'(4'b1011) << w) | 64'(d);
                $display("%s accept data=%0h cycle=%0d", nm, d, cycle);
            end
        end else if (pos == h + w + g) begin
            pos = 0;
        end else begin
            pos++;
        end
    endtask

    task automatic model_check(input string nm, input int h, input int w,
                               input int pos, input logic [63:0] bits,
                               input logic s, input logic [2:0] st, input logic rd,
                               input logic bs, input logic fd);
        logic       e_seq;
        logic [2:0] e_st;
        e_seq = 1'b0;
        if (pos >= 1 && pos <= h + w) e_seq = bits[h + w - pos];
        if (pos == 0)          e_st = 3'd0;
        else if (pos <= h)     e_st = 3'd1;
        else if (pos <= h + w) e_st = 3'd2;
        else                   e_st = 3'd3;
        check({nm, ".seq"},   32'(s),  32'(e_seq));
        check({nm, ".state"}, 32'(st), 32'(e_st));
        check({nm, ".ready"}, 32'(rd), 32'(pos == 0));
        check({nm, ".busy"},  32'(bs), 32'(pos != 0));
        check({nm, ".done"},  32'(fd), 32'(pos == h + w));
    endtask

    task automatic cyc(input logic ra, input logic la, input logic [7:0] da,
                       input logic rb, input logic lb, input logic [3:0] db);
        rst_a = ra; load_a = la; data_a = da;
        rst_b = rb; load_b = lb; data_b = db;
        @(posedge clk);
        model_step("A", 4, 8, 2, ra, la, 32'(da), pos_a, bits_a);
        model_step("B", 4, 4, 0, rb, lb, 32'(db), pos_b, bits_b);
        @(negedge clk);
        cycle++;
        model_check("A", 4, 8, pos_a, bits_a, seq_a, st_a, ready_a, busy_a, done_a);
        model_check("B", 4, 4, pos_b, bits_b, seq_b, st_b, ready_b, busy_b, done_b);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 1, 0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        // Reset, with a load asserted to show reset wins
        cyc(0, 1, 8'hA5, 0, 1, 4'h9);
        cyc(0, 0, 8'h00, 0, 0, 4'h0);
        idle_a(2);

        // Single A5 frame
        cyc(1, 1, 8'hA5, 1, 0, 4'h0);
        idle_a(16);

        // Load held continuously: 3C then FF, back-to-back
        cyc(1, 1, 8'h3C, 1, 0, 4'h0);
        for (int i = 0; i < 15; i++) cyc(1, 1, 8'hFF, 1, 0, 4'h0);
        idle_a(16);

        // Loads of 00 during HDR and DATA are ignored
        cyc(1, 1, 8'hA5, 1, 0, 4'h0);
        for (int i = 1; i < 16; i++) cyc(1, (i == 2 || i == 7), 8'h00, 1, 0, 4'h0);
        idle_a(2);

        // Reset during the 3rd data bit, then a clean 81 frame
        cyc(1, 1, 8'hA5, 1, 0, 4'h0);
        for (int i = 1; i < 7; i++) cyc(1, 0, 8'h00, 1, 0, 4'h0);
        cyc(0, 0, 8'h00, 1, 0, 4'h0);
        cyc(1, 1, 8'h81, 1, 0, 4'h0);
        idle_a(16);

        // Header pattern inside the data
        cyc(1, 1, 8'hB0, 1, 0, 4'h0);
        idle_a(16);

        // Short instance, load held: 9-cycle period
        for (int i = 0; i < 20; i++) cyc(1, 0, 8'h00, 1, 1, 4'h9);
        idle_a(10);

        // Randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 3, 8'($urandom),
                $urandom_range(0, 49) != 0, $urandom_range(0, 9) < 3, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_seq_tx.md
# sd_seq_tx

Serial frame transmitter paired with the team's 1011 sequence detectors. Accepts a parallel data word over a valid/ready handshake. Emits it one bit per clock on `seq_out`, preceded by a fixed sync header (default 1011) and followed by a low guard gap. This lets a downstream detector align on frame starts. Sits between test-pattern or register logic and the serial line feeding the detector FSMs.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits, ≥ 1.
- `HDR`, 4'b1011: sync header pattern, sent MSB first.
- `HDR_LEN`, 4: number of header bits, ≥ 1.
- `GAP_LEN`, 2: guard cycles after the last data bit, ≥ 0. `seq_out` is held at 0 during the gap.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled only on the rising edge of `clk`.
- `data_in`  in  WIDTH  word to transmit; sampled only on the accept edge.
- `load`  in  1  request to transmit `data_in`.
- `ready`  out  1  high only in IDLE; combinational decode of the state.
- `seq_out`  out  1  registered serial output, one bit per cycle.
- `busy`  out  1  high in HDR, DATA and GAP.
- `frame_done`  out  1  registered one-cycle pulse, high while the last data bit is on `seq_out`.
- `state_out`  out  3  current state: IDLE=000, HDR=001, DATA=010, GAP=011.

## Operation
- States: IDLE → HDR → DATA → GAP → IDLE. If `GAP_LEN`=0, DATA goes directly to IDLE.
- IDLE: `seq_out`=0, `ready`=1.
  - Accept edge is the rising edge with `rst`=1, `load`=1 and state IDLE.
  - On the accept edge, `data_in` is copied into the shift register.
  - The bit counter is set for the header, and `seq_out` ← `HDR[HDR_LEN-1]`.
- HDR: each edge shifts out the next header bit, MSB to LSB.
  - After `HDR[0]`, the next edge drives `data_in[WIDTH-1]` and enters DATA.
- DATA: each edge drives the next data bit, MSB first.
  - `frame_done` is 1 exactly while `D[0]` is on `seq_out`.
- GAP: `seq_out`=0 for `GAP_LEN` cycles, then IDLE.
- `load` outside IDLE is ignored: no latch, no queueing, no error. The current frame is unaffected.
- `data_in` changes after the accept edge do not affect the frame in flight.
- Data containing the header pattern (e.g. 8'hB0) is transmitted unmodified. There is no bit stuffing.
- Counter width is $clog2(max(HDR_LEN, WIDTH, GAP_LEN)+1). No wrap occurs within a frame.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `seq_out`=0, `frame_done`=0, `busy`=0, `ready`=1 after that edge, counters and shift register cleared.
  - Reset overrides `load` on the same edge.
  - A mid-frame reset aborts the frame immediately. The next cycle shows `seq_out`=0.
- Accept at edge e0: `seq_out` shows header bit i during the cycle after edge e0+(HDR_LEN-1-i).
- The last data bit is driven from edge e0+HDR_LEN+WIDTH-1.
- Gap runs from edge e0+HDR_LEN+WIDTH up to IDLE at edge e0+HDR_LEN+WIDTH+GAP_LEN.
- Frame period, back-to-back, is HDR_LEN+WIDTH+GAP_LEN+1 cycles. The +1 is the mandatory IDLE cycle in which `ready`=1.
- `ready` falls in the cycle after the accept edge. `busy` is the complement of `ready`.

## Test plan
- Defaults, `load` with `data_in`=8'hA5 for one cycle → `seq_out` = 1,0,1,1,1,0,1,0,0,1,0,1,0,0 starting the cycle after accept. `frame_done` high only on the 12th bit. `ready` high again 15 cycles after accept.
- `load` held high continuously with 8'h3C then 8'hFF → two frames separated by exactly one IDLE cycle. Period 15 cycles. The second frame carries 8'hFF.
- `load` with 8'h00 pulsed during HDR and DATA of an 8'hA5 frame → frame unchanged, no extra frame. `state_out` sequence is 001×4, 010×8, 011×2, 000.
- `rst`=0 for one edge during the 3rd data bit → `seq_out`=0, `state_out`=000, `ready`=1 the next cycle, no `frame_done`. A new `load` of 8'h81 transmits cleanly.
- `data_in`=8'hB0 → output 1011_10110000. The header pattern inside the data is sent verbatim and `frame_done` still falls on the 12th bit.
- `GAP_LEN`=0, `HDR_LEN`=4, `WIDTH`=4, `data_in`=4'h9 → `seq_out` 1,0,1,1,1,0,0,1. IDLE is entered the edge after the last bit, and the back-to-back period is 9 cycles.
